// File: rtl/neuron_term_feeder_pkg.sv
// Shared definitions for the neuron term feeder: fixed-point defaults,
// controller state encoding and saturation limits.
package neuron_term_feeder_pkg;

    localparam int DEF_N = 10;
    localparam int DEF_Q = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [DEF_N-1:0] SAT_MAX = {1'b0, {(DEF_N-1){1'b1}}};
    localparam logic [DEF_N-1:0] SAT_MIN = {1'b1, {(DEF_N-1){1'b0}}};

    // Largest positive N-bit value expressed at product width
    function automatic logic signed [63:0] sat_hi(input int n);
        logic signed [63:0] v;
        v = (64'sd1 <<< (n - 1)) - 64'sd1;
        return v;
    endfunction

    // Most negative N-bit value expressed at product width
    function automatic logic signed [63:0] sat_lo(input int n);
        logic signed [63:0] v;
        v = -(64'sd1 <<< (n - 1));
        return v;
    endfunction

endpackage

// File: rtl/neuron_term_feeder_fx_mul_sat.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift by Q (floor), then clamp into the N-bit signed range.
module fx_mul_sat
    import neuron_term_feeder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int Q = DEF_Q
)(
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);

    localparam int PW = 2 * N;
    localparam logic signed [63:0] HI64 = sat_hi(N);
    localparam logic signed [63:0] LO64 = sat_lo(N);
    localparam logic signed [PW-1:0] HI = HI64[PW-1:0];
    localparam logic signed [PW-1:0] LO = LO64[PW-1:0];

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] shift_s;

    // Multiply, scale back to Q fractional bits and saturate
    always_comb begin
        prod_s  = PW'(a) * PW'(b);
        shift_s = prod_s >>> Q;
        if (shift_s > HI) begin
            y = {1'b0, {(N-1){1'b1}}};
        end else if (shift_s < LO) begin
            y = {1'b1, {(N-1){1'b0}}};
        end else begin
            y = shift_s[N-1:0];
        end
    end

endmodule

// File: rtl/neuron_term_feeder.sv
// Sequences one dot product: clears the downstream accumulator, streams
// addresses 0..LEN-1 and emits one saturated x*w term per cycle.
module neuron_term_feeder
    import neuron_term_feeder_pkg::*;
#(
    parameter int  N   = DEF_N,
    parameter int  Q   = DEF_Q,
    parameter int  LEN = 8,
    localparam int AW  = $clog2(LEN)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [AW-1:0]        x_addr,
    input  logic signed [N-1:0]  x_data,
    output logic [AW-1:0]        w_addr,
    input  logic signed [N-1:0]  w_data,
    output logic signed [N-1:0]  term,
    output logic                 add,
    output logic                 acc_rst,
    output logic                 busy,
    output logic                 done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

    state_e              state_r;
    state_e              state_s;
    logic [AW-1:0]       addr_r;
    logic                data_v_r;
    logic signed [N-1:0] prod_s;
    logic signed [N-1:0] term_r;
    logic                add_r;
    logic                acc_rst_r;
    logic                busy_r;
    logic                done_r;

    fx_mul_sat #(
        .N (N),
        .Q (Q)
    ) u_mul (
        .a (x_data),
        .b (w_data),
        .y (prod_s)
    );

    // Next-state selection; start only matters while idle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_s = ST_FETCH;
            ST_FETCH: begin
                if (addr_r == LAST_ADDR) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, address and output registers; data_v_r marks memory data valid this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= {AW{1'b0}};
            data_v_r  <= 1'b0;
            term_r    <= {N{1'b0}};
            add_r     <= 1'b0;
            acc_rst_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_rst_r <= (state_r == ST_IDLE) && start;
            data_v_r  <= (state_r == ST_CLEAR) || (state_r == ST_FETCH);
            add_r     <= data_v_r;
            done_r    <= (state_r == ST_DONE);
            busy_r    <= (state_s != ST_IDLE);
            if (data_v_r) begin
                term_r <= prod_s;
            end else begin
                term_r <= term_r;
            end
            // Address parks at zero when idle and never wraps past the last element
            if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
                addr_r <= {AW{1'b0}};
            end else if (((state_r == ST_CLEAR) || (state_r == ST_FETCH)) &&
                         (addr_r != LAST_ADDR)) begin
                addr_r <= addr_r + AW'(1);
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    assign x_addr  = addr_r;
    assign w_addr  = addr_r;
    assign term    = term_r;
    assign add     = add_r;
    assign acc_rst = acc_rst_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_neuron_term_feeder.sv
// Self-checking bench for neuron_term_feeder: table vectors, hand-written
// corner sequences and random dot products against an arithmetic reference.
module tb_neuron_term_feeder;

    localparam int N   = 10;
    localparam int Q   = 9;
    localparam int LEN = 8;
    localparam int AW  = $clog2(LEN);

    logic                clk;
    logic                rst;
    logic                start;
    logic [AW-1:0]       x_addr;
    logic [AW-1:0]       w_addr;
    logic signed [N-1:0] x_data;
    logic signed [N-1:0] w_data;
    logic signed [N-1:0] term;
    logic                add;
    logic                acc_rst;
    logic                busy;
    logic                done;

    logic signed [N-1:0] x_mem [LEN];
    logic signed [N-1:0] w_mem [LEN];
    int                  exp_t [LEN];
    int                  exp_dot;

    int tests;
    int fails;

    typedef struct {
        int x;
        int w;
        int exp_term;
    } vec_t;

    vec_t tbl [LEN];

    neuron_term_feeder #(
        .N   (N),
        .Q   (Q),
        .LEN (LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x_addr  (x_addr),
        .x_data  (x_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .term    (term),
        .add     (add),
        .acc_rst (acc_rst),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data follows the address by one cycle
    always @(posedge clk) begin
        x_data <= x_mem[x_addr];
        w_data <= w_mem[w_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // floor(x*w / 2^Q) clamped to the signed N-bit range
    function automatic int ref_term(input int x, input int w);
        int p;
        int r;
        int lim;
        p = x * w;
        r = p / (1 << Q);
        if ((p % (1 << Q) != 0) && (p < 0)) r = r - 1;
        lim = 1 << (N - 1);
        if (r > lim - 1) r = lim - 1;
        else if (r < -lim) r = -lim;
        return r;
    endfunction

    task automatic load(input int k, input int x, input int w);
        x_mem[k] = N'(x);
        w_mem[k] = N'(w);
    endtask

    task automatic compute_expect();
        exp_dot = 0;
        for (int k = 0; k < LEN; k++) begin
            exp_t[k] = ref_term(int'(x_mem[k]), int'(w_mem[k]));
            exp_dot += exp_t[k];
        end
    endtask

    // One full operation; c counts cycles after the edge that samples start
    task automatic run_op(input bit poke);
        int acc;
        int exp_addr;
        acc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < LEN + 3; c++) begin
            @(negedge clk);
            chk("acc_rst", int'(acc_rst), int'(c == 0));
            chk("add", int'(add), int'(c >= 2 && c <= LEN + 1));
            chk("busy", int'(busy), int'(c <= LEN + 1));
            chk("done", int'(done), int'(c == LEN + 2));
            chk("excl", int'(acc_rst & add), 0);
            if (c <= LEN) begin
                exp_addr = (c < LEN - 1) ? c : LEN - 1;
                chk("x_addr", int'(x_addr), exp_addr);
                chk("w_addr", int'(w_addr), exp_addr);
            end
            if (acc_rst) acc = 0;
            if (add) begin
                if (c >= 2 && c <= LEN + 1) chk("term", int'(term), exp_t[c - 2]);
                acc += int'(term);
            end
            if (poke && (c == 4)) start = 1'b1;
            else start = 1'b0;
        end
        chk("dot", acc, exp_dot);
    endtask

    initial begin
        int n_acc;
        int n_add;
        int n_done;
        int held;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < LEN; k++) load(k, 0, 0);

        // Reset values, with start also high to show reset priority
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_add", int'(add), 0);
        chk("rst_acc_rst", int'(acc_rst), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_term", int'(term), 0);
        chk("rst_addr", int'(x_addr), 0);
        start = 1'b0;
        rst   = 1'b0;

        // All 0.5 * 0.5
        for (int k = 0; k < LEN; k++) load(k, 256, 256);
        compute_expect();
        chk("ref_half", exp_dot, 1024);
        run_op(1'b0);

        // Hand-derived table: saturation, floor truncation, mixed signs
        tbl[0] = '{x: -512, w: -512, exp_term: 511};
        tbl[1] = '{x: -512, w: 511,  exp_term: -511};
        tbl[2] = '{x: -1,   w: 1,    exp_term: -1};
        tbl[3] = '{x: 1,    w: 1,    exp_term: 0};
        tbl[4] = '{x: 256,  w: 256,  exp_term: 128};
        tbl[5] = '{x: 511,  w: 511,  exp_term: 510};
        tbl[6] = '{x: -3,   w: 200,  exp_term: -2};
        tbl[7] = '{x: 100,  w: -100, exp_term: -20};
        exp_dot = 0;
        for (int k = 0; k < LEN; k++) begin
            load(k, tbl[k].x, tbl[k].w);
            exp_t[k] = tbl[k].exp_term;
            exp_dot += tbl[k].exp_term;
        end
        run_op(1'b0);

        // start pulsed while busy must be ignored
        run_op(1'b1);

        // Reset during the third add cycle aborts the operation
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c <= 4; c++) @(negedge clk);
        chk("abort_in_add", int'(add), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_add", int'(add), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_term", int'(term), 0);
        chk("abort_addr", int'(x_addr), 0);
        n_add = 0;
        n_done = 0;
        for (int c = 0; c < LEN + 4; c++) begin
            @(negedge clk);
            n_add += int'(add);
            n_done += int'(done);
        end
        chk("abort_no_add", n_add, 0);
        chk("abort_no_done", n_done, 0);
        compute_expect();
        run_op(1'b0);

        // start held high: two operations, acc_rst right after the idle/done cycle
        n_acc = 0;
        n_add = 0;
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 2 * LEN + 5; c++) begin
            @(negedge clk);
            held = (c == 0) || (c == LEN + 3);
            chk("held_acc_rst", int'(acc_rst), held);
            held = (c == LEN + 2) || (c == 2 * LEN + 5);
            chk("held_done", int'(done), held);
            n_acc += int'(acc_rst);
            n_add += int'(add);
            n_done += int'(done);
        end
        start = 1'b0;
        chk("held_n_acc", n_acc, 2);
        chk("held_n_add", n_add, 2 * LEN);
        chk("held_n_done", n_done, 2);
        @(negedge clk);
        chk("held_stop", int'(acc_rst), 0);
        chk("held_idle", int'(busy), 0);

        // Random dot products against the arithmetic reference
        for (int v = 0; v < 100; v++) begin
            for (int k = 0; k < LEN; k++) begin
                if (v % 4 == 0) load(k, int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20);
                else load(k, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
            end
            compute_expect();
            run_op(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
